// File: rtl/tcu.sv
// USB full-speed transmit controller: sequences SYNC, PID, optional payload,
// CRC16 and EOP through the TX shifter / NRZI encoder.
module tcu #(
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [2:0] tx_packet,
  input  logic       rcving,
  input  logic [6:0] buffer_occ,
  input  logic [7:0] tx_data,
  input  logic       byte_sent,
  input  logic       eop_done,
  output logic [7:0] tx_byte,
  output logic       load_byte,
  output logic       get_tx_data,
  output logic       send_eop,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int CW = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_SYNC = 3'd1,
    SEND_PID  = 3'd2,
    SEND_DATA = 3'd3,
    SEND_CRC1 = 3'd4,
    SEND_CRC2 = 3'd5,
    WAIT_EOP  = 3'd6
  } state_t;

  // CRC-16/USB over one byte, LSB first, reflected polynomial.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = {1'b0, c[15:1]};
      if (fb) c = c ^ 16'hA001;
      else    c = c;
    end
    return c;
  endfunction

  function automatic logic [7:0] pid_byte(input logic [2:0] code);
    logic [3:0] p;
    case (code)
      3'd2:    p = 4'b0011;
      3'd3:    p = 4'b1011;
      3'd4:    p = 4'b0010;
      3'd5:    p = 4'b1010;
      3'd6:    p = 4'b1110;
      default: p = 4'b0000;
    endcase
    return {~p, p};
  endfunction

  state_t          state_r, state_s;
  logic [2:0]      code_r, code_s;
  logic [15:0]     crc_r, crc_s;
  logic [CW-1:0]   count_r, count_s;
  logic [7:0]      tx_byte_r, tx_byte_s;
  logic            load_byte_r, load_byte_s;
  logic            send_eop_r, send_eop_s;
  logic            tx_done_r, tx_done_s;
  logic            tx_error_r, tx_error_s;
  logic            tx_active_r;
  logic            pop_s;
  logic            valid_req_s, data_pkt_s, can_pop_s;

  assign valid_req_s = !rcving && (tx_packet >= 3'd2) && (tx_packet <= 3'd6);
  assign data_pkt_s  = (code_r == 3'd2) || (code_r == 3'd3);
  assign can_pop_s   = (buffer_occ != 7'd0) && (count_r < CW'(MAX_BYTES));

  // State register.
  always_ff @(posedge clk) begin
    if (!n_rst) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (tx_start && valid_req_s) state_s = SEND_SYNC;
        else                         state_s = IDLE;
      end
      SEND_SYNC: begin
        if (byte_sent) state_s = SEND_PID;
        else           state_s = SEND_SYNC;
      end
      SEND_PID, SEND_DATA: begin
        if (!byte_sent)                               state_s = state_r;
        else if (state_r == SEND_PID && !data_pkt_s)  state_s = WAIT_EOP;
        else if (can_pop_s)                           state_s = SEND_DATA;
        else                                          state_s = SEND_CRC1;
      end
      SEND_CRC1: begin
        if (byte_sent) state_s = SEND_CRC2;
        else           state_s = SEND_CRC1;
      end
      SEND_CRC2: begin
        if (byte_sent) state_s = WAIT_EOP;
        else           state_s = SEND_CRC2;
      end
      WAIT_EOP: begin
        if (eop_done) state_s = IDLE;
        else          state_s = WAIT_EOP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output / datapath next values; pulses default low, datapath holds.
  always_comb begin
    code_s      = code_r;
    crc_s       = crc_r;
    count_s     = count_r;
    tx_byte_s   = tx_byte_r;
    load_byte_s = 1'b0;
    send_eop_s  = 1'b0;
    tx_done_s   = 1'b0;
    tx_error_s  = 1'b0;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (tx_start && valid_req_s) begin
          code_s      = tx_packet;
          crc_s       = 16'hFFFF;
          count_s     = CW'(0);
          tx_byte_s   = 8'h80;
          load_byte_s = 1'b1;
        end else begin
          tx_error_s  = tx_start;
        end
      end
      SEND_SYNC: begin
        if (byte_sent) begin
          tx_byte_s   = pid_byte(code_r);
          load_byte_s = 1'b1;
        end else begin
          load_byte_s = 1'b0;
        end
      end
      SEND_PID, SEND_DATA: begin
        if (!byte_sent) begin
          load_byte_s = 1'b0;
        end else if (state_r == SEND_PID && !data_pkt_s) begin
          send_eop_s  = 1'b1;
        end else if (can_pop_s) begin
          pop_s       = 1'b1;
          tx_byte_s   = tx_data;
          count_s     = count_r + CW'(1);
          crc_s       = crc16_byte(crc_r, tx_data);
          load_byte_s = 1'b1;
        end else begin
          tx_byte_s   = ~crc_r[7:0];
          load_byte_s = 1'b1;
        end
      end
      SEND_CRC1: begin
        if (byte_sent) begin
          tx_byte_s   = ~crc_r[15:8];
          load_byte_s = 1'b1;
        end else begin
          load_byte_s = 1'b0;
        end
      end
      SEND_CRC2: begin
        if (byte_sent) send_eop_s = 1'b1;
        else           send_eop_s = 1'b0;
      end
      WAIT_EOP: begin
        if (eop_done) tx_done_s = 1'b1;
        else          tx_done_s = 1'b0;
      end
      default: begin
        load_byte_s = 1'b0;
      end
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      code_r      <= 3'd0;
      crc_r       <= 16'hFFFF;
      count_r     <= CW'(0);
      tx_byte_r   <= 8'h00;
      load_byte_r <= 1'b0;
      send_eop_r  <= 1'b0;
      tx_done_r   <= 1'b0;
      tx_error_r  <= 1'b0;
      tx_active_r <= 1'b0;
    end else begin
      code_r      <= code_s;
      crc_r       <= crc_s;
      count_r     <= count_s;
      tx_byte_r   <= tx_byte_s;
      load_byte_r <= load_byte_s;
      send_eop_r  <= send_eop_s;
      tx_done_r   <= tx_done_s;
      tx_error_r  <= tx_error_s;
      tx_active_r <= (state_s != IDLE);
    end
  end

  // The pop strobe is gated by reset so a byte is never lost on a reset edge.
  assign get_tx_data = pop_s & n_rst;
  assign tx_byte     = tx_byte_r;
  assign load_byte   = load_byte_r;
  assign send_eop    = send_eop_r;
  assign tx_active   = tx_active_r;
  assign tx_done     = tx_done_r;
  assign tx_error    = tx_error_r;

endmodule
